i2c_reg_target: RTL and testbench



---
 rtl/i2c_reg_target.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C target with an internal 8-bit register bank.
// SCL and SDA are oversampled on clk; the bus protocol is decoded entirely in the clk domain.
// A write transfer sets the register pointer and then writes data bytes. The pointer
// auto-increments and wraps. A read transfer returns bytes starting at the current pointer.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] app_raddr,
  output logic [7:0]       app_rdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_prev, sda_prev;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             rw_q, rw_d;
  logic             sda_oe_d, busy_d;
  logic             bank_we;
  logic [7:0]       wr_byte, rd_byte;
  logic [7:0]       bank [NUM_REGS];

  // Synchronise the pads and keep the previous synced level for edge detection.
  // The flops reset to the idle-bus level, so leaving reset never looks like a START.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: clocked state uses non-blocking assignments, so every flop in this block samples the pre-edge values together.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev & sda_s;

  assign ptr_inc   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  assign rd_byte   = bank[ptr_q];
  assign app_rdata = bank[app_raddr];

  // Protocol state register and its shift/count/pointer datapath.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
    end
  end

  // Next-state decode. Bits are sampled on SCL rise. sda_oe only moves on SCL fall.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    bank_we   = 1'b0;
    wr_byte   = {shift_q[6:0], sda_s};

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // busy is held until the new address byte decides it.
      state_d   = ADDR;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, PTR: begin
          if (scl_rise) begin
            shift_d   = wr_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                state_d  = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = WAIT;
              end
            end else if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
              ptr_d    = shift_q[PTR_W-1:0];
              sda_oe_d = 1'b1;
              state_d  = PTR_ACK;
            end else begin
              state_d = WAIT;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_d   = wr_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bank_we = 1'b1;
              ptr_d   = ptr_inc;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          // The pointer advances past the byte just read whether or not the host acknowledged it.
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (sda_s) state_d = WAIT;
          end else if (scl_fall) begin
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end
        WAIT: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Register bank write port and the registered write strobe seen by the application.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      // NOTE: the bank is built from resettable flops rather than RAM, because every register must read 0x00 after reset.
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= bank_we;
      if (bank_we) begin
        bank[ptr_q] <= wr_byte;
        wr_addr     <= ptr_q;
        wr_data     <= wr_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target. A bit-banged host drives the bus.
// A transaction-level model holds the bank contents, the pointer and the expected writes.
// One compare process checks the outputs every cycle.
module tb_i2c_reg_target;

  localparam int NUM_REGS    = 16;
  localparam int SYNC_STAGES = 2;
  localparam int PTR_W       = 4;
  localparam int Q           = 8;   // clk cycles per quarter SCL period

  logic             clk = 1'b0;
  logic             nRst;
  logic             scl_i;
  logic             sda_m;
  logic             sda_line;
  logic             sda_oe;
  logic [PTR_W-1:0] app_raddr;
  logic [7:0]       app_rdata;
  logic             wr_stb;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             busy;

  // The bus is open drain: either side can pull SDA low.
  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_reg_target #(
    .DEV_ADDR   (7'h42),
    .NUM_REGS   (NUM_REGS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .scl_i    (scl_i),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .app_raddr(app_raddr),
    .app_rdata(app_rdata),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  wr_t        cur;
  logic [7:0] m_bank [NUM_REGS];
  int         m_ptr;
  logic       oe_seen;
  logic       prev_oe  = 1'b0;
  logic       prev_scl = 1'b1;
  logic [7:0] scl_hist = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < NUM_REGS; i++) m_bank[i] = '0;
      exp_q.delete();
      prev_oe = 1'b0;
    end else begin
      if (sda_oe) oe_seen = 1'b1;
      check("sda_oe_moved_scl_high", (sda_oe != prev_oe) && scl_i && prev_scl, 0);
      check("wr_stb_unexpected", wr_stb && (exp_q.size() == 0), 0);
      if (wr_stb && exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("wr_addr", wr_addr, cur.addr);
        check("wr_data", wr_data, cur.data);
        check("wr_stb_latency", {scl_hist[SYNC_STAGES], scl_hist[SYNC_STAGES+1]}, 2'b10);
        m_bank[cur.addr] = cur.data;
      end
      check("app_rdata", app_rdata, m_bank[app_raddr]);
      prev_oe = sda_oe;
    end
    scl_hist = {scl_hist[6:0], scl_i};
    prev_scl = scl_i;
  end

  // Host bus primitives. Inputs change 2 ns after the rising clk edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(Q);
    scl_i = 1'b1; hold(Q);
    sda_m = 1'b0; hold(Q);
    scl_i = 1'b0; hold(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(Q);
    scl_i = 1'b1; hold(Q);
    sda_m = 1'b1; hold(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    hold(Q);
    scl_i = 1'b1; hold(2 * Q);
    scl_i = 1'b0; hold(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; hold(Q);
    scl_i = 1'b1; hold(Q);
    b = sda_line; hold(Q);
    scl_i = 1'b0; hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  // Transaction-level operations that keep the model in step.
  task automatic addr_phase(input logic [7:0] a, input logic exp_ack, input string name);
    logic ack;
    write_byte(a, ack);
    check(name, ack, exp_ack);
  endtask

  task automatic ptr_phase(input logic [7:0] p, input string name);
    logic ack, exp_ack;
    exp_ack = (p < NUM_REGS);
    write_byte(p, ack);
    check(name, ack, exp_ack);
    if (exp_ack) m_ptr = p;
  endtask

  task automatic data_write(input logic [7:0] d, input string name);
    logic ack;
    wr_t  e;
    e.addr = m_ptr;
    e.data = d;
    exp_q.push_back(e);
    write_byte(d, ack);
    check(name, ack, 1);
    m_ptr = (m_ptr + 1) % NUM_REGS;
  endtask

  task automatic data_read(input logic ack, input string name, output logic [7:0] d);
    logic [7:0] exp_d;
    exp_d = m_bank[m_ptr];
    read_byte(d, ack);
    check(name, d, exp_d);
    m_ptr = (m_ptr + 1) % NUM_REGS;
  endtask

  task automatic rd_reg(input int a, input logic [7:0] exp, input string name);
    @(posedge clk); #2;
    app_raddr = PTR_W'(a);
    @(negedge clk);
    check(name, app_rdata, exp);
  endtask

  task automatic idle_checks(input string name);
    hold(2);
    @(negedge clk);
    check({name, "_busy"}, busy, 0);
    check({name, "_writes_done"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       ack;
    nRst = 1'b0; scl_i = 1'b1; sda_m = 1'b1; app_raddr = '0; m_ptr = 0; oe_seen = 1'b0;
    hold(4);
    @(negedge clk);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_stb", wr_stb, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_app_rdata", app_rdata, 0);
    hold(1); nRst = 1'b1; hold(4);

    // Pointer write followed by two data bytes.
    i2c_start();
    addr_phase(8'h84, 1, "wr_addr_ack");
    @(negedge clk);
    check("busy_after_match", busy, 1);
    ptr_phase(8'h03, "wr_ptr_ack");
    data_write(8'hA5, "wr_d0_ack");
    data_write(8'h5A, "wr_d1_ack");
    i2c_stop();
    idle_checks("write");
    rd_reg(4, 8'h5A, "bank4_lit");
    rd_reg(3, 8'hA5, "bank3_lit");

    // Place a marker in register 5 so the final pointer position can be observed.
    i2c_start(); addr_phase(8'h84, 1, "mark_addr_ack"); ptr_phase(8'h05, "mark_ptr_ack");
    data_write(8'hC3, "mark_d_ack"); i2c_stop(); idle_checks("mark");

    // Random read: write the pointer, issue a repeated START, then read two bytes.
    i2c_start(); addr_phase(8'h84, 1, "rr_addr_ack"); ptr_phase(8'h03, "rr_ptr_ack");
    i2c_start(); addr_phase(8'h85, 1, "rr_raddr_ack");
    data_read(1'b1, "rr_d0", d); check("rr_d0_lit", d, 8'hA5);
    data_read(1'b0, "rr_d1", d); check("rr_d1_lit", d, 8'h5A);
    i2c_stop(); idle_checks("rr");
    check("model_ptr_after_rr", m_ptr, 5);
    i2c_start(); addr_phase(8'h85, 1, "cur_addr_ack");
    data_read(1'b0, "cur_rd", d); check("cur_rd_lit", d, 8'hC3);
    i2c_stop(); idle_checks("cur");

    // Address mismatch.
    oe_seen = 1'b0;
    i2c_start(); addr_phase(8'h90, 0, "mismatch_nack");
    @(negedge clk);
    check("mismatch_busy", busy, 0);
    i2c_stop(); idle_checks("mismatch");
    check("mismatch_oe_never", oe_seen, 0);

    // Pointer out of range: NACK, and the data byte that follows is ignored.
    i2c_start(); addr_phase(8'h84, 1, "badptr_addr_ack");
    ptr_phase(8'h10, "badptr_nack");
    write_byte(8'h99, ack); check("badptr_data_nack", ack, 0);
    i2c_stop(); idle_checks("badptr");

    // Pointer wraps from the last register back to register 0.
    i2c_start(); addr_phase(8'h84, 1, "wrap_addr_ack"); ptr_phase(8'h0F, "wrap_ptr_ack");
    data_write(8'h11, "wrap_d0_ack"); data_write(8'h22, "wrap_d1_ack");
    i2c_stop(); idle_checks("wrap");
    rd_reg(15, 8'h11, "bank15_lit");
    rd_reg(0, 8'h22, "bank0_lit");

    // STOP after four data bits discards the partial byte; the next transfer works normally.
    i2c_start(); addr_phase(8'h84, 1, "abort_addr_ack"); ptr_phase(8'h02, "abort_ptr_ack");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop(); idle_checks("abort");
    rd_reg(2, 8'h00, "abort_no_write");
    i2c_start(); addr_phase(8'h84, 1, "after_abort_addr_ack"); ptr_phase(8'h07, "after_abort_ptr_ack");
    data_write(8'h3C, "after_abort_d_ack"); i2c_stop(); idle_checks("after_abort");
    rd_reg(7, 8'h3C, "bank7_lit");

    // Assert reset in the middle of a read while the target is pulling SDA low.
    i2c_start(); addr_phase(8'h84, 1, "rst_addr_ack"); ptr_phase(8'h07, "rst_ptr_ack");
    i2c_start(); addr_phase(8'h85, 1, "rst_raddr_ack");
    hold(2);
    @(negedge clk);
    check("rd_driving_before_reset", sda_oe, 1);
    hold(1);
    nRst = 1'b0;
    #1;
    check("reset_async_sda_oe", sda_oe, 0);
    check("reset_async_busy", busy, 0);
    m_ptr = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      app_raddr = PTR_W'(i);
      #1;
      check("reset_bank_clear", app_rdata, 0);
    end
    scl_i = 1'b1; sda_m = 1'b1;
    hold(4); nRst = 1'b1; hold(4);

    // After reset the pointer is 0 and the bank reads back as zero.
    i2c_start(); addr_phase(8'h85, 1, "post_rst_addr_ack");
    data_read(1'b0, "post_rst_rd", d); check("post_rst_rd_lit", d, 8'h00);
    i2c_stop(); idle_checks("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
